// File: rtl/tt_trng_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tt_trng_pkg
//  Purpose  : Shared constants and types for the TRNG debias / key-capture
//             slice (default nibble width, default repetition limit, and the
//             von Neumann pair-state encoding).
//  Revision : 1.0  initial release
// ============================================================================
package tt_trng_pkg;

    localparam int unsigned TT_NIB_W         = 4;
    localparam int unsigned TT_RCT_LIMIT_DEF = 8;

    typedef enum logic {
        PAIR_EMPTY = 1'b0,
        PAIR_HELD  = 1'b1
    } pair_state_t;

endpackage
`default_nettype wire

// File: rtl/tt_rct_check.sv
`default_nettype none
// ============================================================================
//  Module   : tt_rct_check
//  Purpose  : Repetition-count health test on the raw TRNG bit. Counts runs
//             of identical bit_in values on bit_en cycles and raises a sticky
//             fail flag one cycle after the run length reaches RCT_LIMIT.
//  Ports    : clk, rst        clock / synchronous active-high reset
//             bit_in, bit_en  raw bit and its consume strobe
//             health_fail     sticky fail flag (cleared only by rst)
//  Revision : 1.0  initial release
// ============================================================================
module tt_rct_check
    import tt_trng_pkg::*;
#(
    parameter int unsigned RCT_LIMIT = TT_RCT_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic bit_en,
    output logic health_fail
);

    localparam logic [7:0] c_limit = 8'(RCT_LIMIT);

    logic [7:0] r_run_q,  w_run_d;
    logic       r_last_q, w_last_d;
    logic       r_fail_q, w_fail_d;

    always_comb begin
        w_run_d  = r_run_q;
        w_last_d = r_last_q;
        // The flag follows the registered run length, so it lands one cycle
        // after the run reaches the limit.
        w_fail_d = r_fail_q | (r_run_q == c_limit);
        if (bit_en) begin
            w_last_d = bit_in;
            // A zero run means no previous bit since reset.
            if ((r_run_q == 8'd0) || (bit_in != r_last_q)) begin
                w_run_d = 8'd1;
            end else if (r_run_q != c_limit) begin
                w_run_d = r_run_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_q  <= 8'd0;
            r_last_q <= 1'b0;
            r_fail_q <= 1'b0;
        end else begin
            r_run_q  <= w_run_d;
            r_last_q <= w_last_d;
            r_fail_q <= w_fail_d;
        end
    end

    assign health_fail = r_fail_q;

endmodule
`default_nettype wire

// File: rtl/tt_debias_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tt_debias_pack
//  Purpose  : von Neumann corrector on the raw TRNG bit, packing corrected
//             bits into an NIB_W-bit sliding window, and capturing one fresh
//             nibble on each rising edge of the sample button.
//  Macro    : TT_DEBIAS_RCT_EN - when defined, a repetition-count health test
//             (tt_rct_check) blocks captures once the raw source sticks;
//             when undefined, health_fail is tied 0.
//  Ports    : clk, rst       clock / synchronous active-high reset
//             bit_in, bit_en raw random bit and its consume strobe
//             sample         capture request (rising edge acts)
//             nibble_out     last captured key
//             nibble_valid   nibble_out holds a capture (sticky)
//             nibble_ready   NIB_W fresh corrected bits available
//             cap_pulse      one-cycle capture strobe
//             health_fail    repetition test tripped (sticky)
//  Revision : 1.0  initial release
// ============================================================================
module tt_debias_pack
    import tt_trng_pkg::*;
#(
    parameter int unsigned NIB_W     = TT_NIB_W,
    parameter int unsigned RCT_LIMIT = TT_RCT_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             sample,
    output logic [NIB_W-1:0] nibble_out,
    output logic             nibble_valid,
    output logic             nibble_ready,
    output logic             cap_pulse,
    output logic             health_fail
);

    localparam int unsigned        c_cnt_w    = $clog2(NIB_W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(NIB_W);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    generate
        if ((RCT_LIMIT < 2) || (RCT_LIMIT > 255)) begin : g_bad_rct_limit
            $error("tt_debias_pack: RCT_LIMIT must be in 2..255");
        end
        if (NIB_W < 2) begin : g_bad_nib_w
            $error("tt_debias_pack: NIB_W must be at least 2");
        end
    endgenerate

    pair_state_t        r_pair_q,   w_pair_d;
    logic               r_a_q,      w_a_d;
    logic [NIB_W-1:0]   r_shreg_q,  w_shreg_d;
    logic [c_cnt_w-1:0] r_count_q,  w_count_d;
    logic               r_ready_q,  w_ready_d;
    logic               r_sample_q;
    logic [NIB_W-1:0]   r_nibble_q, w_nibble_d;
    logic               r_valid_q,  w_valid_d;
    logic               r_cap_q;

    logic               w_emit;
    logic               w_edge;
    logic               w_capture;
    logic               w_health_fail;
    logic [c_cnt_w-1:0] w_count_base;

    // Pair FSM: the corrected bit is always the first bit of an unequal pair.
    always_comb begin
        w_pair_d = r_pair_q;
        w_a_d    = r_a_q;
        w_emit   = 1'b0;
        if (bit_en) begin
            if (r_pair_q == PAIR_EMPTY) begin
                w_a_d    = bit_in;
                w_pair_d = PAIR_HELD;
            end else begin
                w_emit   = r_a_q ^ bit_in;
                w_pair_d = PAIR_EMPTY;
            end
        end
    end

    assign w_edge    = sample & ~r_sample_q;
    assign w_capture = w_edge & r_ready_q & ~w_health_fail;

    // Packer and capture. A capture takes the pre-emit window; a bit emitted
    // in the same cycle still shifts in and counts as the first fresh bit.
    always_comb begin
        w_shreg_d    = r_shreg_q;
        w_count_base = w_capture ? '0 : r_count_q;
        w_count_d    = w_count_base;
        if (w_emit) begin
            w_shreg_d = {r_shreg_q[NIB_W-2:0], r_a_q};
            if (w_count_base != c_cnt_full) begin
                w_count_d = w_count_base + c_cnt_one;
            end
        end
        w_ready_d  = (w_count_d == c_cnt_full);
        w_nibble_d = w_capture ? r_shreg_q : r_nibble_q;
        w_valid_d  = r_valid_q | w_capture;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pair_q   <= PAIR_EMPTY;
            r_a_q      <= 1'b0;
            r_shreg_q  <= '0;
            r_count_q  <= '0;
            r_ready_q  <= 1'b0;
            r_sample_q <= 1'b0;
            r_nibble_q <= '0;
            r_valid_q  <= 1'b0;
            r_cap_q    <= 1'b0;
        end else begin
            r_pair_q   <= w_pair_d;
            r_a_q      <= w_a_d;
            r_shreg_q  <= w_shreg_d;
            r_count_q  <= w_count_d;
            r_ready_q  <= w_ready_d;
            r_sample_q <= sample;
            r_nibble_q <= w_nibble_d;
            r_valid_q  <= w_valid_d;
            r_cap_q    <= w_capture;
        end
    end

`ifdef TT_DEBIAS_RCT_EN
    tt_rct_check #(
        .RCT_LIMIT   (RCT_LIMIT)
    ) u_rct_check (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_en      (bit_en),
        .health_fail (w_health_fail)
    );
`else
    assign w_health_fail = 1'b0;
`endif

    assign nibble_out   = r_nibble_q;
    assign nibble_valid = r_valid_q;
    assign nibble_ready = r_ready_q;
    assign cap_pulse    = r_cap_q;
    assign health_fail  = w_health_fail;

endmodule
`default_nettype wire
